// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, IF/ID payload type and PC helper for the fetch stage
package fetch_stage_pkg;

  localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic [31:0] instr;
    logic        vld;
  } if_id_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register; bubble outranks hold, reset loads a NOP bubble
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_hold,
  input  logic   i_bubble,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t data_q;
  if_id_t data_d;
  if_id_t bubble_val;

  assign bubble_val = '{pc: 32'h0, pc_four: 32'h0, instr: NOP_INSTR, vld: 1'b0};

  always_comb begin
    data_d = data_q;
    if (i_bubble) begin
      data_d = bubble_val;
    end else if (!i_hold) begin
      data_d = i_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      data_q <= bubble_val;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_q = data_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, next-PC mux and IF/ID capture; FETCH_MISALIGN_CHK_EN adds a sticky misaligned-redirect flag
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_pc_four,
  output logic [31:0] o_id_instr,
  output logic        o_id_vld,
  output logic        o_misalign_err
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect wins over stall so the wrong-path flush is never lost.
  always_comb begin
    pc_d = pc_q;
    if (i_redirect) begin
      pc_d = align_pc(i_redirect_pc);
    end else if (!i_stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign if_id_d = '{pc: pc_q, pc_four: pc_plus4, instr: i_imem_rdata, vld: 1'b1};

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_hold  (i_stall),
    .i_bubble(i_redirect),
    .i_d     (if_id_d),
    .o_q     (if_id_q)
  );

  assign o_imem_addr  = pc_q;
  assign o_id_pc      = if_id_q.pc;
  assign o_id_pc_four = if_id_q.pc_four;
  assign o_id_instr   = if_id_q.instr;
  assign o_id_vld     = if_id_q.vld;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;
  logic misalign_d;

  assign misalign_d = misalign_q | (i_redirect & (|i_redirect_pc[1:0]));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign o_misalign_err = misalign_q;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
  assign o_misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a cycle model
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] HI_RST = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redir;
  logic [31:0] redir_pc;

  logic [31:0] imem_addr, imem_rdata, id_pc, id_pc_four, id_instr;
  logic        id_vld, mis_err;
  logic [31:0] hi_addr, hi_rdata, hi_pc, hi_pc_four, hi_instr;
  logic        hi_vld, hi_err;

  assign imem_rdata = imem_addr ^ KEY;
  assign hi_rdata   = hi_addr ^ KEY;

  fetch_stage dut (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_redirect(redir),
    .i_redirect_pc(redir_pc), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
    .o_id_pc(id_pc), .o_id_pc_four(id_pc_four), .o_id_instr(id_instr),
    .o_id_vld(id_vld), .o_misalign_err(mis_err)
  );

  fetch_stage #(.RESET_PC(HI_RST)) dut_hi (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_redirect(redir),
    .i_redirect_pc(redir_pc), .o_imem_addr(hi_addr), .i_imem_rdata(hi_rdata),
    .o_id_pc(hi_pc), .o_id_pc_four(hi_pc_four), .o_id_instr(hi_instr),
    .o_id_vld(hi_vld), .o_misalign_err(hi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference state: what fetch "should" hold, derived from the priority rules.
  logic [31:0] m_pc, m_id_pc, m_id_four, m_id_instr;
  logic        m_vld, m_err;
  bit          chk_en;

  initial begin
`ifdef FETCH_MISALIGN_CHK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
  end

  task automatic model_reset();
    m_pc = 32'h0; m_id_pc = 32'h0; m_id_four = 32'h0;
    m_id_instr = NOP; m_vld = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    if (redir) begin
      if (chk_en && redir_pc[1:0] != 2'b00) m_err = 1'b1;
      m_pc = redir_pc & 32'hFFFF_FFFC;
      m_id_pc = 32'h0; m_id_four = 32'h0; m_id_instr = NOP; m_vld = 1'b0;
    end else if (!stall) begin
      m_id_pc = m_pc; m_id_four = m_pc + 32'd4; m_id_instr = m_pc ^ KEY; m_vld = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".addr"},  imem_addr,  m_pc);
    check({tag, ".pc"},    id_pc,      m_id_pc);
    check({tag, ".four"},  id_pc_four, m_id_four);
    check({tag, ".instr"}, id_instr,   m_id_instr);
    check({tag, ".vld"},   {31'b0, id_vld},  {31'b0, m_vld});
    check({tag, ".err"},   {31'b0, mis_err}, {31'b0, m_err});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    #1 rst = 1'b1;
    model_reset();
    #1 compare_all("reset");
    check("hi.reset.addr", hi_addr, HI_RST);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 compare_all("post_reset");
    check("hi.post_reset.addr", hi_addr, HI_RST);

    step("run0");
    check("hi.run0.addr", hi_addr, 32'hFFFF_FFFC);
    check("hi.run0.pc", hi_pc, HI_RST);
    step("run1");
    check("hi.wrap.addr", hi_addr, 32'h0000_0000);
    check("hi.wrap.four", hi_pc_four, 32'h0000_0000);
    check("hi.wrap.err", {31'b0, hi_err}, 32'h0);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) step("stall");
    stall = 1'b0;
    step("unstall");
    check("unstall.pc8", id_pc, 32'h8);

    redir = 1'b1; stall = 1'b1; redir_pc = 32'h0000_0100;
    step("redir");
    check("redir.nop", id_instr, 32'h0000_0013);
    redir = 1'b0; stall = 1'b0;
    step("redir_tgt");
    check("redir_tgt.pc", id_pc, 32'h100);

    redir = 1'b1; redir_pc = 32'h0000_0102;
    step("misalign");
    check("misalign.pc", imem_addr, 32'h100);
    check("misalign.flag", {31'b0, mis_err}, {31'b0, chk_en});
    redir = 1'b0;
    for (int i = 0; i < 3; i++) step("sticky");

    for (int i = 0; i < 300; i++) begin
      stall    = ($urandom_range(0, 99) < 30);
      redir    = ($urandom_range(0, 99) < 10);
      redir_pc = $urandom;
      step("rand");
    end

    redir = 1'b0; stall = 1'b1;
    step("pre_async");
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all("async_rst");
    #1 rst = 1'b0; stall = 1'b0;
    step("after_rst");
    check("after_rst.pc", id_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the bubble instruction.
REQ-003 SHALL have i_clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have i_reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have i_stall, input, 1, hold PC and IF/ID (load-use or RAW hazard from decode).
REQ-006 SHALL have i_redirect, input, 1, taken branch/jump resolved downstream.
REQ-007 SHALL have i_redirect_pc, input, 32, redirect target address.
REQ-008 SHALL have o_imem_addr, output, 32, instruction memory read address.
REQ-009 SHALL have i_imem_rdata, input, 32, instruction word, valid in the same cycle as o_imem_addr (asynchronous read).
REQ-010 SHALL have o_id_pc, output, 32, PC of the instruction held in IF/ID.
REQ-011 SHALL have o_id_pc_four, output, 32, o_id_pc + 4.
REQ-012 SHALL have o_id_instr, output, 32, instruction presented to the decode/control stage.
REQ-013 SHALL have o_id_vld, output, 1, o_id_instr is a real fetched instruction, not a bubble.
REQ-014 SHALL have o_misalign_err, output, 1, sticky misaligned-redirect flag (see Configuration).

Function
REQ-015 SHALL drive o_imem_addr combinationally from the internal PC register pc_q.
REQ-016 SHALL apply, on each rising edge, the priority reset > redirect > stall > advance.
REQ-017 Advance SHALL perform pc_q <= pc_q+4 and load IF/ID with {pc_q, pc_q+4, i_imem_rdata, vld=1}.
REQ-018 Stall SHALL hold pc_q and all IF/ID fields unchanged.
REQ-019 Redirect SHALL perform pc_q <= {i_redirect_pc[31:2],2'b00} and load IF/ID with {0, 0, NOP_INSTR, vld=0}, one-cycle wrong-path flush, regardless of i_stall.
REQ-020 Redirect-to-first-valid-IF/ID latency SHALL be 2 cycles: edge 1 loads the target into pc_q, edge 2 captures the target instruction.
REQ-021 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without error.
REQ-022 o_id_pc_four SHALL be registered, not recomputed from o_id_pc.
REQ-023 A stall held for N cycles SHALL leave IF/ID and pc_q unchanged for all N cycles.
REQ-024 The first advance after stall release SHALL capture the instruction at the held pc_q.
REQ-025 Outputs SHALL contain no combinational path from i_stall or i_redirect.

Reset
REQ-026 On i_reset=1, asynchronously: pc_q=RESET_PC, o_id_pc=0, o_id_pc_four=0, o_id_instr=NOP_INSTR, o_id_vld=0, o_misalign_err=0.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL override both; the first advance after release fetches RESET_PC.

Configuration
REQ-028 Macro FETCH_MISALIGN_CHK_EN defined: a redirect with i_redirect_pc[1:0]!=0 SHALL set o_misalign_err=1, held until reset; the PC is still aligned per REQ-019.
REQ-029 Macro undefined: o_misalign_err SHALL be tied 0, and the low target bits SHALL be silently cleared.

Structure
REQ-030 Shared package SHALL hold NOP_INSTR, the RESET_PC default, and a packed if_id_t struct {pc, pc_four, instr, vld}.
REQ-031 The IF/ID pipeline register SHALL be a sub-module if_id_reg with hold and bubble controls; PC register, +4 adder and next-PC mux stay in fetch_stage.

Verification
REQ-032 Reset release, no stall, imem returns addr^32'hA5A5_0000 -> o_imem_addr 0,4,8; IF/ID vld=1 with pc 0 from the first edge after release.
REQ-033 i_stall high 3 cycles at pc_q=8 -> o_imem_addr stays 8, IF/ID holds pc 4, then resumes capturing pc 8.
REQ-034 i_redirect=1, target 32'h0000_0100, with i_stall=1 -> next cycle o_imem_addr=0x100, o_id_vld=0, o_id_instr=0x00000013; next cycle o_id_pc=0x100, vld=1.
REQ-035 RESET_PC=32'hFFFF_FFF8, free run -> o_imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000; o_misalign_err stays 0.
REQ-036 Redirect target 32'h0000_0102 -> pc_q=0x100; o_misalign_err=1 with the macro and stays 1 until reset, 0 without the macro.
REQ-037 i_reset pulsed asynchronously mid-stall -> outputs at reset values immediately, without waiting for a clock edge.
